seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter. Accepts a parallel bit pattern with a length and repeat count through a valid/ready handshake, then shifts it out one bit per clock, MSB of the active field first. Repetitions are optionally separated by idle gap cycles. It is the stimulus and transmit side for the team's serial sequence detectors, and it drives their single-bit serial input.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (width of pattern port)
LEN_W, 4, width of len port; must satisfy 2^LEN_W > MAX_LEN
CNT_W, 4, width of repeat port
GAP, 0, idle cycles (x_valid=0, x_out=0) inserted between consecutive repetitions

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
pattern  input  MAX_LEN  bits to send; pattern[len-1] is sent first, pattern[0] last
len  input  LEN_W  number of bits per repetition
repeat  input  CNT_W  extra repetitions; total sends = repeat+1
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
x_out  output  1  serial data bit (registered)
x_valid  output  1  x_out carries a pattern bit this cycle (registered)
busy  output  1  request accepted and not yet finished
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- One clock, synchronous active-high reset; no other clock or reset.
- Reset values: in_ready=1, x_out=0, x_valid=0, busy=0, done=0; FSM in IDLE; internal registers cleared.
- FSM states: IDLE, SHIFT, GAP, DONE. in_ready=1 only in IDLE. busy=1 in SHIFT and GAP.
- Accept: rising edge with in_valid=1 and in_ready=1 (cycle T). The block captures pattern, len and repeat at this edge. Later changes to these inputs do not affect the transfer in flight. in_valid is ignored outside IDLE.
- len clamping: len>MAX_LEN is treated as MAX_LEN.
- len=0: IDLE goes to DONE. done=1 at T+1, no bits sent, repeat ignored, in_ready=1 at T+2.
- Timing for len>=1:
  - First bit pattern[len-1] appears on x_out with x_valid=1 in cycle T+1.
  - Each bit is held exactly one cycle, descending index, ending at pattern[0].
  - x_out and x_valid come directly from flops; no combinational path from inputs.
- End of a repetition, when repetitions remain:
  - GAP=0: the next repetition's first bit follows the previous last bit with no bubble.
  - GAP>0: GAP cycles of x_valid=0 and x_out=0, then SHIFT restarts from bit len-1.
- End of the final repetition: next cycle is DONE. done=1, x_valid=0, x_out=0, busy=0, in_ready=0. The cycle after that returns to IDLE with in_ready=1.
- Total cycles from the accept edge to done: (repeat+1)*len + repeat*GAP + 1.
- Counters:
  - bit index counter is LEN_W wide and counts down.
  - repetition counter is CNT_W wide and counts down with no wrap. repeat = 2^CNT_W-1 gives exactly 2^CNT_W sends.
- A request presented during DONE is not accepted; it is accepted in the following IDLE cycle if still valid.
- Reset mid-operation:
  - The transfer is abandoned and done is not pulsed.
  - Outputs take reset values in the cycle after the reset edge.
  - Reset has priority over any simultaneous in_valid.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 -> in_ready=1, x_valid=0, busy=0, done=0 throughout; nothing accepted.
- pattern=8'b0000_0101, len=3, repeat=0, accept at T -> x_out=1,0,1 with x_valid=1 at T+1..T+3; done=1 at T+4; in_ready=1 at T+5.
- Same pattern, repeat=1, GAP=0 -> x_out=1,0,1,1,0,1 at T+1..T+6, x_valid continuously 1; done at T+7.
- GAP=2 build, pattern=8'b1100_0000, len=8, repeat=1 -> bits 1,1,0,0,0,0,0,0 at T+1..T+8; x_valid=0 at T+9..T+10; second copy at T+11..T+18; done at T+19.
- len=0 -> done at T+1, x_valid never 1. Separately, len=12 with MAX_LEN=8 -> exactly 8 bits sent, pattern[7] first.
- Assert reset at T+2 of a len=8 transfer -> x_valid=0 and in_ready=1 after the reset edge, no done pulse. Change pattern mid-transfer (no reset) -> output is unaffected.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a pattern/length/repeat request and
// shifts it out MSB-of-field first, one bit per clock, with optional idle gaps.
module seq_pattern_tx #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   repeat_cnt,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               x_out,
  output logic               x_valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  // Handshake: a request transfers on a rising edge where in_valid and
  // in_ready are both 1; in_ready is high only in IDLE, in_valid is ignored otherwise.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int                GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  ONE_L     = LEN_W'(1);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
  localparam logic [GAP_W-1:0]  ONE_G     = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     rep_q, rep_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 x_out_q, x_out_d;
  logic                 x_valid_q, x_valid_d;
  logic [LEN_W-1:0]     len_in;

  // Selects one pattern bit without an index wider than the pattern needs.
  function automatic logic bit_at(input logic [MAX_LEN-1:0] p,
                                  input logic [LEN_W-1:0]   idx);
    bit_at = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == LEN_W'(i)) bit_at = p[i];
    end
  endfunction

  assign len_in = (len > MAX_LEN_L) ? MAX_LEN_L : len;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_d     = rep_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    x_out_d   = 1'b0;
    x_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pat_d = pattern;
          len_d = len_in;
          rep_d = repeat_cnt;
          if (len_in == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_SHIFT;
            idx_d     = len_in - ONE_L;
            x_valid_d = 1'b1;
            x_out_d   = bit_at(pattern, len_in - ONE_L);
          end
        end
      end
      S_SHIFT: begin
        if (idx_q != '0) begin
          idx_d     = idx_q - ONE_L;
          x_valid_d = 1'b1;
          x_out_d   = bit_at(pat_q, idx_q - ONE_L);
        end else if (rep_q != '0) begin
          rep_d = rep_q - ONE_C;
          // Without a gap the next copy starts on the very next cycle.
          if (GAP == 0) begin
            idx_d     = len_q - ONE_L;
            x_valid_d = 1'b1;
            x_out_d   = bit_at(pat_q, len_q - ONE_L);
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d   = S_SHIFT;
          idx_d     = len_q - ONE_L;
          x_valid_d = 1'b1;
          x_out_d   = bit_at(pat_q, len_q - ONE_L);
        end else begin
          gap_d = gap_q - ONE_G;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
    end
  end

  assign x_out     = x_out_q;
  assign x_valid   = x_valid_q;
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (GAP=0 and GAP=2) driven with random
// requests; expected per-cycle output streams come from a queue-based model.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] repeat_cnt = '0;
  logic       iv0 = 1'b0, iv2 = 1'b0;
  logic       rdy0, xo0, xv0, busy0, done0;
  logic       rdy2, xo2, xv2, busy2, done2;
  logic [1:0] st0, st2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seq_pattern_tx #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .pattern(pattern), .len(len),
    .repeat_cnt(repeat_cnt), .in_valid(iv0), .in_ready(rdy0), .x_out(xo0),
    .x_valid(xv0), .busy(busy0), .done(done0), .state_dbg(st0)
  );

  seq_pattern_tx #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .pattern(pattern), .len(len),
    .repeat_cnt(repeat_cnt), .in_valid(iv2), .in_ready(rdy2), .x_out(xo2),
    .x_valid(xv2), .busy(busy2), .done(done2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  // Each entry is one active cycle: {x_valid, x_out, done}.
  logic [2:0] exp_q0[$];
  logic [2:0] exp_q2[$];
  logic [2:0] mdl_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the full sequence of active cycles a request should produce.
  function automatic void model(input logic [7:0] pat, input int l, input int rep, input int gap);
    int n;
    mdl_q.delete();
    n = (l > 8) ? 8 : l;
    if (n > 0) begin
      for (int r = 0; r <= rep; r++) begin
        for (int i = n - 1; i >= 0; i--) mdl_q.push_back({1'b1, pat[i], 1'b0});
        if (r < rep) for (int g = 0; g < gap; g++) mdl_q.push_back(3'b000);
      end
    end
    mdl_q.push_back(3'b001);
  endfunction

  task automatic mon(input int d, input logic rdy, input logic xv, input logic xo,
                     input logic bz, input logic dn);
    logic [2:0] e;
    int n;
    n = (d == 0) ? exp_q0.size() : exp_q2.size();
    if (reset) begin
      check($sformatf("d%0d_reset_outs", d), {3'b0, rdy, xv, xo, bz, dn}, 8'b0001_0000);
    end else if (n > 0 || bz || dn) begin
      if (n == 0) begin
        check($sformatf("d%0d_unexpected_active", d), {6'b0, bz, dn}, 8'h00);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q2.pop_front();
        check($sformatf("d%0d_stream", d), {3'b0, rdy, e, bz},
              {3'b0, 1'b0, e, ~e[0]} == {3'b0, rdy, e, bz} ? {3'b0, rdy, e, bz} : {3'b0, 1'b0, e, ~e[0]});
        check($sformatf("d%0d_stream_out", d), {4'b0, rdy, xv, xo, dn}, {4'b0, 1'b0, e});
        check($sformatf("d%0d_stream_busy", d), {7'b0, bz}, {7'b0, ~e[0]});
      end
    end else begin
      check($sformatf("d%0d_idle_outs", d), {3'b0, rdy, xv, xo, bz, dn}, 8'b0001_0000);
    end
  endtask

  always @(negedge clk) begin
    mon(0, rdy0, xv0, xo0, busy0, done0);
    mon(2, rdy2, xv2, xo2, busy2, done2);
  end

  // ---------------- driver tasks ----------------
  // All driver steps happen 1 time unit after a falling edge.
  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy0 : rdy2;
  endfunction

  task automatic set_valid(input int d, input logic v);
    if (d == 0) iv0 = v;
    else        iv2 = v;
  endtask

  task automatic send(input int d, input logic [7:0] pat, input int l, input int rep,
                      input bit scramble);
    int waited;
    waited = 0;
    pattern = pat;
    len = l[3:0];
    repeat_cnt = rep[3:0];
    set_valid(d, 1'b1);
    while (!rdy_of(d) && waited < 500) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!rdy_of(d)) begin
      check($sformatf("d%0d_accept_timeout", d), 8'd0, 8'd1);
      set_valid(d, 1'b0);
    end else begin
      model(pat, l, rep, (d == 0) ? 0 : 2);
      foreach (mdl_q[i]) begin
        if (d == 0) exp_q0.push_back(mdl_q[i]);
        else        exp_q2.push_back(mdl_q[i]);
      end
      @(negedge clk); #1;
      set_valid(d, 1'b0);
      if (scramble) begin
        pattern = 8'($urandom);
        len = 4'($urandom);
        repeat_cnt = 4'($urandom);
      end
    end
  endtask

  task automatic wait_idle(input int d);
    int waited;
    waited = 0;
    while (((d == 0) ? exp_q0.size() : exp_q2.size()) != 0 || !rdy_of(d)) begin
      if (waited >= 2000) break;
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 2000) begin
      check($sformatf("d%0d_idle_timeout", d), 8'd0, 8'd1);
      if (d == 0) exp_q0.delete();
      else        exp_q2.delete();
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    iv0 = 1'b1;
    iv2 = 1'b1;
    exp_q0.delete();
    exp_q2.delete();
    repeat (cycles) begin
      @(negedge clk); #1;
    end
    iv0 = 1'b0;
    iv2 = 1'b0;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    do_reset(3);
    @(negedge clk); #1;

    send(0, 8'b0000_0101, 3, 0, 1'b0);
    wait_idle(0);
    send(0, 8'b0000_0101, 3, 1, 1'b1);
    wait_idle(0);
    send(0, 8'($urandom), 0, 5, 1'b0);
    send(0, 8'($urandom), 12, 1, 1'b1);
    wait_idle(0);
    send(0, 8'($urandom), 1, 15, 1'b0);
    wait_idle(0);
    for (int k = 0; k < 25; k++) begin
      send(0, 8'($urandom), $urandom_range(0, 12), $urandom_range(0, 3),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) wait_idle(0);
    end
    wait_idle(0);

    send(2, 8'b1100_0000, 8, 1, 1'b1);
    wait_idle(2);
    for (int k = 0; k < 10; k++) begin
      send(2, 8'($urandom), $urandom_range(0, 12), $urandom_range(0, 2),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) wait_idle(2);
    end
    wait_idle(2);

    send(0, 8'hA5, 8, 0, 1'b0);
    @(negedge clk); #1;
    do_reset(2);
    repeat (3) begin
      @(negedge clk); #1;
    end
    send(0, 8'h3C, 6, 1, 1'b1);
    wait_idle(0);
    repeat (4) begin
      @(negedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
